// File: rtl/dmem_refill_responder_pkg.sv
// dmem_refill_responder_pkg: shared types and helpers for the refill responder.
//   - state_t      : responder FSM states
//   - WORD_W       : data/address word width
//   - BYTE_OFF_W   : byte-offset bits below the word address
//   - width_of()   : counter/index width helper (never below 1 bit)
//   - beat_order() : line position transferred on a given beat
// Optional feature macro: DMEM_CRITICAL_WORD_FIRST_EN (requested word first, wrapping in the line).
package dmem_refill_responder_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;

`ifdef DMEM_CRITICAL_WORD_FIRST_EN
  localparam bit CWF_EN = 1'b1;
`else
  localparam bit CWF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_t;

  // Bits needed to index n entries, clamped to 1 so zero-width vectors never appear.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Line position of beat `beat`; line_words is a power of two.
  function automatic int unsigned beat_order(input int unsigned start_word,
                                             input int unsigned beat,
                                             input int unsigned line_words);
    return CWF_EN ? ((start_word + beat) & (line_words - 1)) : (beat & (line_words - 1));
  endfunction

endpackage

// File: rtl/dmem_refill_responder_if.sv
// dmem_refill_responder_if: cache <-> memory miss-path bus.
//   master (cache) drives mem_req/mem_we/mem_addr/mem_wdata;
//   slave (responder) drives mem_wr_ready/mem_rdata/mem_rd_valid/mem_done/mem_busy.
interface dmem_refill_responder_if;
  import dmem_refill_responder_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_wr_ready;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_rd_valid;
  logic              mem_done;
  logic              mem_busy;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_wr_ready, mem_rdata, mem_rd_valid, mem_done, mem_busy
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_wr_ready, mem_rdata, mem_rd_valid, mem_done, mem_busy
  );

endinterface

// File: rtl/dmem_refill_responder_word_array.sv
// dmem_word_array: single-port word RAM, synchronous read, write enable.
//   clk, rst (sync active-low, clears only the read register)
//   en/we/addr/wdata : access port; rdata : registered read data
module dmem_word_array
  import dmem_refill_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = width_of(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage is never reset so contents survive an aborted transaction.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read register: holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_refill_responder.sv
// dmem_refill_responder: memory-side responder for data-cache line refills/writebacks.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset (aborts any transaction, memory kept)
//   bus  : dmem_refill_responder_if.slave (request, writeback data, refill data, done/busy)
// Parameters: LINE_WORDS (power of two, >=2), LATENCY (>=0), MEM_WORDS (power of two).
// Optional feature macro: DMEM_CRITICAL_WORD_FIRST_EN (beat 0 is the requested word).
module dmem_refill_responder
  import dmem_refill_responder_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned LATENCY    = 50,
  parameter int unsigned MEM_WORDS  = 4096
) (
  input logic                    clk,
  input logic                    rst,
  dmem_refill_responder_if.slave bus
);

  localparam int unsigned OW = width_of(LINE_WORDS);
  localparam int unsigned AW = width_of(MEM_WORDS);
  localparam int unsigned CW = width_of(LATENCY);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     line_q, line_d;
  logic [OW-1:0]     start_q, start_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ready_q, wr_ready_d;
  logic              done_q, done_d;

  logic              ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  // Address bits that never reach the array (byte lane, aliased upper bits).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[BYTE_OFF_W-1:0], bus.mem_addr[WORD_W-1:AW+BYTE_OFF_W]};

  // Array index of a beat; line base has its low OW bits clear, so no carry leaves the line.
  function automatic logic [AW-1:0] beat_index(input logic [AW-1:0] line,
                                               input logic [OW-1:0] start,
                                               input logic [OW-1:0] beat);
    return line + AW'(beat_order(32'(start), 32'(beat), LINE_WORDS));
  endfunction

  // Next-state, registered-output and array-port decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    line_d  = line_q;
    start_d = start_q;
    we_d    = we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_req) begin
          line_d  = {bus.mem_addr[AW+BYTE_OFF_W-1:OW+BYTE_OFF_W], {OW{1'b0}}};
          start_d = bus.mem_addr[OW+BYTE_OFF_W-1:BYTE_OFF_W];
          we_d    = bus.mem_we;
          beat_d  = '0;
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_XFER;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_XFER: begin
        if (beat_q == OW'(LINE_WORDS - 1)) begin
          state_d = ST_DONE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + OW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    busy_d     = (state_d != ST_IDLE);
    rd_valid_d = (state_d == ST_XFER) && !we_d;
    wr_ready_d = (state_d == ST_XFER) && we_d;
    done_d     = (state_d == ST_DONE);

    // Writes use the current beat; reads are issued one cycle ahead using the next beat,
    // which also covers the zero-latency path straight out of IDLE.
    ram_we   = rst && (state_q == ST_XFER) && we_q;
    ram_re   = (state_d == ST_XFER) && !we_d;
    ram_addr = ram_we ? beat_index(line_q, start_q, beat_q)
                      : beat_index(line_d, start_d, beat_d);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      start_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      start_q    <= start_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
      done_q     <= done_d;
    end
  end

  dmem_word_array #(
    .DEPTH (MEM_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_we || ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.mem_wdata),
    .rdata (ram_rdata)
  );

  assign bus.mem_busy     = busy_q;
  assign bus.mem_rd_valid = rd_valid_q;
  assign bus.mem_wr_ready = wr_ready_q;
  assign bus.mem_done     = done_q;
  assign bus.mem_rdata    = ram_rdata;

endmodule

// File: tb/tb_dmem_refill_responder.sv
// tb_dmem_refill_responder: directed + randomized bench for dmem_refill_responder.
// Two instances (LATENCY=3 and LATENCY=0, LINE_WORDS=4) share one set of cache-side drives;
// `sel` routes the request to one of them. A word-level memory model predicts refill data.
module tb_dmem_refill_responder;

  localparam int unsigned LW  = 4;
  localparam int unsigned LAT = 3;
  localparam int unsigned MW  = 4096;

`ifdef DMEM_CRITICAL_WORD_FIRST_EN
  localparam bit REF_CWF = 1'b1;
`else
  localparam bit REF_CWF = 1'b0;
`endif

  typedef logic [31:0] line_t [LW];

  logic        clk = 1'b0;
  logic        rst;
  bit          req, we, sel;
  logic [31:0] addr, wdata;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] mdl [int unsigned];

  dmem_refill_responder_if bus3 ();
  dmem_refill_responder_if bus0 ();

  assign bus3.mem_req   = req && !sel;
  assign bus3.mem_we    = we;
  assign bus3.mem_addr  = addr;
  assign bus3.mem_wdata = wdata;
  assign bus0.mem_req   = req && sel;
  assign bus0.mem_we    = we;
  assign bus0.mem_addr  = addr;
  assign bus0.mem_wdata = wdata;

  logic        o_busy, o_rdv, o_wrr, o_done;
  logic [31:0] o_rdata;
  assign o_busy  = sel ? bus0.mem_busy     : bus3.mem_busy;
  assign o_rdv   = sel ? bus0.mem_rd_valid : bus3.mem_rd_valid;
  assign o_wrr   = sel ? bus0.mem_wr_ready : bus3.mem_wr_ready;
  assign o_done  = sel ? bus0.mem_done     : bus3.mem_done;
  assign o_rdata = sel ? bus0.mem_rdata    : bus3.mem_rdata;

  dmem_refill_responder #(.LINE_WORDS(LW), .LATENCY(LAT), .MEM_WORDS(MW)) dut (
    .clk (clk), .rst (rst), .bus (bus3.slave)
  );

  dmem_refill_responder #(.LINE_WORDS(LW), .LATENCY(0), .MEM_WORDS(MW)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
      $error("%s observed %h required %h", tag, obs, exp);
    end
  endtask

  // Line position carried by beat b for a request whose start word is sw.
  function automatic int unsigned ref_order(input int unsigned sw, input int unsigned b);
    return REF_CWF ? (sw + b) % LW : b;
  endfunction

  // Model key: one memory per instance, word index wraps modulo MW.
  function automatic int unsigned mkey(input bit s, input logic [31:0] a, input int unsigned pos);
    int unsigned base = ((a >> 2) / LW) * LW;
    return (s ? MW : 0) + (base + pos) % MW;
  endfunction

  // Full transaction, called in the middle of an idle cycle; ends in the next idle cycle.
  task automatic txn(input bit s, input bit w, input logic [31:0] a, input line_t d, input bit hold);
    int unsigned lat = s ? 0 : LAT;
    int unsigned sw  = (a >> 2) % LW;
    bit          in_beat;
    int unsigned b;
    sel   = s;
    we    = w;
    addr  = a;
    wdata = d[ref_order(sw, 0)];
    req   = 1'b1;
    @(posedge clk);
    for (int unsigned k = 1; k <= lat + LW + 1; k++) begin
      @(negedge clk);
      in_beat = (k >= lat + 1) && (k <= lat + LW);
      b       = k - lat - 1;
      chk("busy", 32'(o_busy), 32'd1);
      chk("rd_valid", 32'(o_rdv), 32'(in_beat && !w));
      chk("wr_ready", 32'(o_wrr), 32'(in_beat && w));
      chk("done", 32'(o_done), 32'(k == lat + LW + 1));
      if (in_beat && !w) chk("rdata", o_rdata, mdl[mkey(s, a, ref_order(sw, b))]);
      if (in_beat && w) begin
        wdata = d[ref_order(sw, b)];
        mdl[mkey(s, a, ref_order(sw, b))] = wdata;
      end
      if (k == lat + LW + 1 && !hold) req = 1'b0;
    end
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);
    if (!hold) begin
      @(negedge clk);
      chk("stay_idle", 32'(o_busy), 32'd0);
    end
  endtask

  line_t       da, db, dr;
  logic [31:0] ra, ra2;
  bit          rs, rh;

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus3.mem_busy), 32'd0);
    chk("rst_rdv", 32'(bus3.mem_rd_valid), 32'd0);
    chk("rst_wrr", 32'(bus3.mem_wr_ready), 32'd0);
    chk("rst_done", 32'(bus3.mem_done), 32'd0);
    chk("rst_rdata", bus3.mem_rdata, 32'd0);
    chk("rst_busy0", 32'(bus0.mem_busy), 32'd0);
    chk("rst_rdata0", bus0.mem_rdata, 32'd0);
    rst = 1'b1;

    // Writeback then refills of the same line, incl. back-to-back and aliased address.
    da = '{32'h11, 32'h22, 32'h33, 32'h44};
    txn(1'b0, 1'b1, 32'h40, da, 1'b0);
    txn(1'b0, 1'b0, 32'h4C, da, 1'b0);
    txn(1'b0, 1'b0, 32'h48, da, 1'b1);
    txn(1'b0, 1'b0, 32'h40, da, 1'b0);
    txn(1'b0, 1'b0, 32'(4 * MW) + 32'h40, da, 1'b0);

    // Reset held two cycles during a refill's wait.
    sel = 1'b0; we = 1'b0; addr = 32'h40; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(o_busy), 32'd1);
    rst = 1'b0; req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mr_busy", 32'(o_busy), 32'd0);
      chk("mr_rdv", 32'(o_rdv), 32'd0);
      chk("mr_wrr", 32'(o_wrr), 32'd0);
      chk("mr_done", 32'(o_done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mr_idle", 32'(o_busy), 32'd0);

    // Writeback aborted by reset during beat 2: only beats 0 and 1 land.
    da = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    db = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    txn(1'b0, 1'b1, 32'h80, da, 1'b0);
    sel = 1'b0; we = 1'b1; addr = 32'h80; wdata = db[0]; req = 1'b1;
    @(posedge clk);
    for (int unsigned k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("ab_busy", 32'(o_busy), 32'd1);
      chk("ab_wrr", 32'(o_wrr), 32'(k >= 4));
      if (k >= 4) begin
        wdata = db[ref_order(0, k - 4)];
        if (k < 6) mdl[mkey(1'b0, 32'h80, ref_order(0, k - 4))] = wdata;
      end
      if (k == 6) begin
        rst = 1'b0;
        req = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_done", 32'(o_done), 32'd0);
      chk("ab_busy_lo", 32'(o_busy), 32'd0);
      rst = 1'b1;
    end
    txn(1'b0, 1'b0, 32'h80, da, 1'b0);
    chk("ab_word2", mdl[mkey(1'b0, 32'h80, 2)], 32'hA2);
    chk("ab_word1", mdl[mkey(1'b0, 32'h80, 1)], 32'hB1);

    // Zero-latency instance: first beat right after the sampling edge.
    da = '{32'h55, 32'h66, 32'h77, 32'h88};
    txn(1'b1, 1'b1, 32'h40, da, 1'b0);
    txn(1'b1, 1'b0, 32'h44, da, 1'b0);

    // Randomized writeback/refill pairs with aliasing and random start words.
    for (int i = 0; i < 10; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      rh = $urandom_range(0, 1) == 1;
      ra = $urandom;
      for (int p = 0; p < int'(LW); p++) dr[p] = $urandom;
      txn(rs, 1'b1, ra, dr, rh);
      ra2 = (ra & ~32'hF) | (32'($urandom_range(0, LW - 1)) << 2);
      ra2 = ra2 + 32'($urandom_range(0, 3)) * 32'(4 * MW);
      txn(rs, 1'b0, ra2, dr, (i == 9) ? 1'b0 : rh);
    end
    req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_refill_responder.md
# dmem_refill_responder

Memory-side responder for the data cache's miss path. It accepts line-refill and line-writeback requests that the cache raises after a miss, waits a configurable access latency, then streams one 32-bit word per cycle into or out of a backing word-addressed memory array. It sits between the data cache in the MEM-stage write-back unit and main memory, and acts as the stand-in main memory for core simulation and FPGA builds.

## Interface
- `LINE_WORDS`, 8: words per cache line; power of two, ≥2.
- `LATENCY`, 50: wait cycles before the first beat; 0 is legal.
- `MEM_WORDS`, 4096: backing array depth in 32-bit words; power of two.
- `clk` input 1: the single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `mem_req` input 1: request; level, held by the cache until `mem_done`.
- `mem_we` input 1: 1 = writeback (cache→memory), 0 = refill (memory→cache).
- `mem_addr` input 32: byte address; bits [log2(LINE_WORDS)+1:0] select the requested word, upper bits select the line.
- `mem_wdata` input 32: writeback word, consumed on each edge with `mem_wr_ready`=1.
- `mem_wr_ready` output 1: writeback beat accepted this cycle.
- `mem_rdata` output 32: refill word, valid with `mem_rd_valid`.
- `mem_rd_valid` output 1: refill beat present this cycle.
- `mem_done` output 1: one-cycle pulse that ends the transaction.
- `mem_busy` output 1: high in WAIT, XFER and DONE.

## Operation
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE: `mem_req`=1 at an edge latches the line address, the start word and `mem_we`. With `LATENCY`>0 the FSM goes to WAIT and loads the countdown with `LATENCY`-1. With `LATENCY`=0 it goes straight to XFER.
- WAIT: the countdown decrements each cycle. At 0 the FSM goes to XFER with beat counter = 0.
- XFER: exactly `LINE_WORDS` cycles. Beat i maps to word index ((line_base + order(i)) mod `MEM_WORDS`). In default build, order(i) = i.
  - Refill: `mem_rd_valid`=1 and `mem_rdata` = array[index].
  - Writeback: `mem_wr_ready`=1, and array[index] ← `mem_wdata` at the edge.
  - After the last beat the FSM goes to DONE.
- DONE: `mem_done`=1 for one cycle, then IDLE. If `mem_req` is still high in the following IDLE cycle, that is a new transaction.
- `mem_addr`, `mem_we` and `mem_wdata` outside accepted beats are ignored while busy.
- Address arithmetic: line_base = word address with its low log2(LINE_WORDS) bits cleared. The word index wraps modulo `MEM_WORDS`, so aliasing is silent.
- Reset: all outputs 0, FSM IDLE, counters 0. Array contents are not cleared. Reset asserted mid-transaction aborts it; words already written stay written, and no `mem_done` is issued.

## Timing
- Request sampled at edge E0. WAIT occupies cycles 1..`LATENCY`. Beats occupy cycles `LATENCY`+1..`LATENCY`+`LINE_WORDS`. `mem_done` is in cycle `LATENCY`+`LINE_WORDS`+1.
- All outputs are registered. `mem_rdata` comes from a synchronous array read issued one cycle ahead, so there are no bubbles between beats.
- Writeback: the cache must present word order(0) before the first beat and advance on every edge where `mem_wr_ready`=1. There is no backpressure.
- With `mem_req` held continuously, `mem_busy` is low for exactly one cycle between transactions.

## Configuration
- `DMEM_CRITICAL_WORD_FIRST_EN` defined: order(i) = (start_word + i) mod `LINE_WORDS`, so the requested word is beat 0 and beats wrap within the line. This applies to both refill and writeback.
- Not defined: order(i) = i and the start word is ignored.

## Structure
- Shared package: FSM state encoding, `log2` offset-width constants, beat-order function.
- One sub-module, `dmem_word_array`: single-port, synchronous-read, write-enable word RAM of depth `MEM_WORDS`. It infers BRAM.

## Test plan
All scenarios use `LINE_WORDS`=4 and `LATENCY`=3.
- Reset: `rst`=0 for 2 cycles mid-run → `mem_busy`, `mem_rd_valid`, `mem_wr_ready`, `mem_done` all 0 at the next edge; FSM in IDLE.
- Writeback to 0x40 with 0x11, 0x22, 0x33, 0x44 → `mem_wr_ready` high in cycles 4–7 and `mem_done` in cycle 8. A following refill of 0x4C returns 0x11, 0x22, 0x33, 0x44 in cycles 4–7.
- With `DMEM_CRITICAL_WORD_FIRST_EN`: refill of 0x48 on that line → 0x33, 0x44, 0x11, 0x22.
- Back-to-back: `mem_req` held high through `mem_done` → second transaction is accepted in the IDLE cycle right after DONE, and `mem_busy` is low exactly one cycle.
- Reset mid-writeback: line 0x80 holds 0xA0–0xA3. A writeback of 0xB0–0xB3 is aborted by `rst`=0 during beat 2 → no `mem_done` is issued. A later refill of 0x80 returns 0xB0, 0xB1, 0xA2, 0xA3.
- Wrap: refill of byte address 4·`MEM_WORDS` + 0x40 → same data as 0x40. `LATENCY`=0 variant: first `mem_rd_valid` in cycle 1.
